// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier.
//   state_t : controller states (IDLE / BUSY / DONE)
//   cnt_w() : width of the step counter and busy-cycle counter for a given
//             operand width; it holds values 0..width inclusive.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mul_step.sv
// One combinational iteration of the shift-add multiplier.
//   a_reg    in  WIDTH      multiplicand
//   b_reg    in  WIDTH      remaining multiplier bits (LSB is consumed now)
//   o_reg    in  OUT_WIDTH  partial product so far
//   cnt      in  CNT_W      index of the multiplier bit being consumed
//   o_next   out OUT_WIDTH  partial product after this step
//   b_next   out WIDTH      multiplier shifted right by one
//   shortcut out 1          nothing left to add, so the result is final
// Macro MUL_CONSTANT_TIME_EN: when defined, shortcut is tied low so every
// operation runs the full WIDTH steps regardless of operand values.
module mul_step #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 4,
    parameter int OUT_WIDTH = 16
) (
    input  logic [WIDTH-1:0]     a_reg,
    input  logic [WIDTH-1:0]     b_reg,
    input  logic [OUT_WIDTH-1:0] o_reg,
    input  logic [CNT_W-1:0]     cnt,
    output logic [OUT_WIDTH-1:0] o_next,
    output logic [WIDTH-1:0]     b_next,
    output logic                 shortcut
);

    logic [OUT_WIDTH-1:0] addend;

    // Zero-extend before shifting so no multiplicand bits are lost.
    assign addend = b_reg[0] ? (OUT_WIDTH'(a_reg) << cnt) : '0;
    assign o_next = o_reg + addend;
    assign b_next = b_reg >> 1;

`ifdef MUL_CONSTANT_TIME_EN
    assign shortcut = 1'b0;
`else
    assign shortcut = (a_reg == '0) || (b_reg == '0);
`endif

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-add multiplier with valid/ready handshakes.
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   stall        in   freezes every register and blocks both handshakes
//   in_valid     in   operand offer;  in_ready out  operands accepted
//   a, b         in   WIDTH-bit unsigned operands
//   out_valid    out  product valid;  out_ready in  consumer accepts
//   product      out  OUT_WIDTH-bit a*b, held until the next operation starts
//   busy_cycles  out  BUSY cycles spent on the current product
//   a_reg_next, b_reg_next, o_reg_next  out  next-state values before the
//                stall gate, for shadow/contract logic
// Macro MUL_CONSTANT_TIME_EN: when defined, every operation takes exactly
// WIDTH BUSY cycles (early termination on zero operands is disabled).
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_w(WIDTH),
    localparam int OUT_WIDTH = 2 * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] product,
    output logic [CNT_W-1:0]     busy_cycles,
    output logic [WIDTH-1:0]     a_reg_next,
    output logic [WIDTH-1:0]     b_reg_next,
    output logic [OUT_WIDTH-1:0] o_reg_next
);

    state_t               state, state_nx;
    logic [WIDTH-1:0]     a_reg, b_reg;
    logic [OUT_WIDTH-1:0] o_reg;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [CNT_W-1:0]     busy_nx;

    logic [OUT_WIDTH-1:0] step_o;
    logic [WIDTH-1:0]     step_b;
    logic                 step_shortcut;

    mul_step #(
        .WIDTH     (WIDTH),
        .CNT_W     (CNT_W),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_step (
        .a_reg    (a_reg),
        .b_reg    (b_reg),
        .o_reg    (o_reg),
        .cnt      (cnt),
        .o_next   (step_o),
        .b_next   (step_b),
        .shortcut (step_shortcut)
    );

    assign in_ready  = (state == IDLE) && !stall;
    assign out_valid = (state == DONE);
    assign product   = o_reg;

    // Next state is computed as if stall were low; the register process
    // applies the stall gate, which also blocks both handshakes.
    always_comb begin
        state_nx   = state;
        a_reg_next = a_reg;
        b_reg_next = b_reg;
        o_reg_next = o_reg;
        cnt_nx     = cnt;
        busy_nx    = busy_cycles;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_reg_next = a;
                    b_reg_next = b;
                    o_reg_next = '0;
                    cnt_nx     = '0;
                    busy_nx    = '0;
                    state_nx   = BUSY;
                end
            end
            BUSY: begin
                busy_nx = busy_cycles + CNT_W'(1);
                if (step_shortcut) begin
                    state_nx = DONE;
                end else begin
                    o_reg_next = step_o;
                    b_reg_next = step_b;
                    cnt_nx     = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            o_reg       <= '0;
            cnt         <= '0;
            busy_cycles <= '0;
        end else if (!stall) begin
            state       <= state_nx;
            a_reg       <= a_reg_next;
            b_reg       <= b_reg_next;
            o_reg       <= o_reg_next;
            cnt         <= cnt_nx;
            busy_cycles <= busy_nx;
        end
    end

endmodule

// File: tb/tb_shift_add_mul.sv
module tb_shift_add_mul;

    localparam int W  = 4;
    localparam int CW = 3;
    localparam int OW = 8;
`ifdef MUL_CONSTANT_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] product;
    logic [CW-1:0] busy_cycles;
    logic [W-1:0]  a_reg_next, b_reg_next;
    logic [OW-1:0] o_reg_next;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    shift_add_mul #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .busy_cycles (busy_cycles),
        .a_reg_next  (a_reg_next),
        .b_reg_next  (b_reg_next),
        .o_reg_next  (o_reg_next)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers operands, checks the pre-stall next values, and returns just
    // after the handshake edge.
    task automatic start_op(input int av, input int bv);
        a = W'(av);
        b = W'(bv);
        in_valid = 1'b1;
        #1;
        chk("start_in_ready", int'(in_ready), 1);
        chk("start_a_next", int'(a_reg_next), av);
        chk("start_b_next", int'(b_reg_next), bv);
        chk("start_o_next", int'(o_reg_next), 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_op(input string tag, input int exp_p, input int exp_bc,
                             input int exp_n);
        int n;
        wait_done(n);
        chk({tag, "_latency"}, n, exp_n);
        chk({tag, "_product"}, int'(product), exp_p);
        chk({tag, "_busy"}, int'(busy_cycles), exp_bc);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_clr"}, int'(out_valid), 0);
        chk({tag, "_in_ready_back"}, int'(in_ready), 1);
        chk({tag, "_product_hold"}, int'(product), exp_p);
    endtask

    initial begin
        #2;
        chk("rst_product", int'(product), 0);
        chk("rst_busy", int'(busy_cycles), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", int'(in_ready), 1);
        tick();

        start_op(3, 5);
        finish_op("mul_3x5", 15, 4, 4);

        start_op(0, 9);
        finish_op("mul_0x9", 0, CT ? 4 : 1, CT ? 4 : 1);

        start_op(7, 1);
        finish_op("mul_7x1", 7, CT ? 4 : 2, CT ? 4 : 2);

        start_op(1, 8);
        finish_op("mul_1x8", 8, 4, 4);

        start_op(15, 0);
        finish_op("mul_15x0", 0, CT ? 4 : 1, CT ? 4 : 1);

        // Stall for 3 cycles after the first BUSY step.
        start_op(15, 15);
        tick();
        stall = 1'b1;
        #1;
        chk("stall_o_next", int'(o_reg_next), 45);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_product_frozen", int'(product), 15);
            chk("stall_busy_frozen", int'(busy_cycles), 1);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        stall = 1'b0;
        wait_done(lat);
        chk("stall_latency", lat + 4, 7);
        chk("stall_product", int'(product), 225);
        chk("stall_busy", int'(busy_cycles), 4);
        // A stalled DONE must not complete the output handshake.
        stall = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("stall_done_hold", int'(out_valid), 1);
        stall = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("stall_done_release", int'(out_valid), 0);

        // Back-pressure: consumer not ready for 4 cycles.
        start_op(6, 3);
        wait_done(lat);
        chk("bp_latency", lat, CT ? 4 : 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_product_hold", int'(product), 18);
            chk("bp_out_valid_hold", int'(out_valid), 1);
            chk("bp_in_ready_low", int'(in_ready), 0);
        end
        // Operands offered outside IDLE are ignored.
        a = 4'd9;
        b = 4'd9;
        in_valid = 1'b1;
        tick();
        chk("bp_ignore_in", int'(product), 18);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_in_ready_after", int'(in_ready), 1);
        chk("bp_product_idle", int'(product), 18);

        // Reset in the middle of BUSY.
        start_op(9, 5);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_product", int'(product), 0);
        chk("midrst_busy", int'(busy_cycles), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_a_next", int'(a_reg_next), 0);
        chk("midrst_o_next", int'(o_reg_next), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        start_op(2, 2);
        finish_op("mul_2x2", 4, CT ? 4 : 3, CT ? 4 : 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
